// File: rtl/apb_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter_if
//
// Bundles every non-clock/reset signal of apb_req_arbiter.
//   Requester side : REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_STRB (to arbiter)
//                    ACK, RDATA, ERR, GNT_ID, BUSY           (from arbiter)
//   Master command : PTX, WRITE, ADDR, WDATA, STRB           (from arbiter)
//   Bus status     : PSEL, PENABLE, PREADY, PSLVERR, PRDATA  (to arbiter)
//
// Modports:
//   slave  - the arbiter's view (consumes requests and bus status).
//   master - the environment's view (requesters plus the APB bus).
// ---------------------------------------------------------------------------
interface apb_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int GW   = $clog2(NREQ)
);

  // Requester side
  logic [NREQ-1:0]          REQ;
  logic [NREQ-1:0]          REQ_WRITE;
  logic [NREQ*AW-1:0]       REQ_ADDR;
  logic [NREQ*DW-1:0]       REQ_WDATA;
  logic [NREQ*(DW/8)-1:0]   REQ_STRB;
  logic [NREQ-1:0]          ACK;
  logic [DW-1:0]            RDATA;
  logic                     ERR;
  logic [GW-1:0]            GNT_ID;
  logic                     BUSY;

  // Command to the APB master
  logic                     PTX;
  logic                     WRITE;
  logic [AW-1:0]            ADDR;
  logic [DW-1:0]            WDATA;
  logic [DW/8-1:0]          STRB;

  // APB phase / status
  logic                     PSEL;
  logic                     PENABLE;
  logic                     PREADY;
  logic                     PSLVERR;
  logic [DW-1:0]            PRDATA;

  modport slave (
    input  REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_STRB,
    input  PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    output ACK, RDATA, ERR, GNT_ID, BUSY,
    output PTX, WRITE, ADDR, WDATA, STRB
  );

  modport master (
    output REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_STRB,
    output PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    input  ACK, RDATA, ERR, GNT_ID, BUSY,
    input  PTX, WRITE, ADDR, WDATA, STRB
  );

endinterface

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter/sequencer sharing one APB master among NREQ requesters.
// One request is served at a time: the winner's fields are latched and
// presented to the master with PTX, the bus is watched for completion
// (PSEL & PENABLE & PREADY), and a one-cycle ACK with RDATA/ERR is returned
// to the winner.
//
// Ports:
//   PCLK    - clock
//   PRESET  - asynchronous active-low reset (aborts any transfer, no ACK)
//   bus     - apb_req_arbiter_if.slave: requester inputs, ACK/RDATA/ERR/
//             GNT_ID/BUSY, master command PTX/WRITE/ADDR/WDATA/STRB and
//             APB status PSEL/PENABLE/PREADY/PSLVERR/PRDATA
//
// Optional feature (compile-time macro APB_ARB_TIMEOUT_EN):
//   When defined, a transfer that has not completed after TIMEOUT BUSY
//   cycles is abandoned and acknowledged with ERR=1, RDATA=0. When not
//   defined, BUSY waits indefinitely and TIMEOUT has no effect.
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic                   PCLK,
  input logic                   PRESET,
  apb_req_arbiter_if.slave      bus
);

  localparam int GW = $clog2(NREQ);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [GW-1:0]     ptr_r;
  logic [GW-1:0]     gnt_r;
  logic              ptx_r;
  logic              busy_r;
  logic [NREQ-1:0]   ack_r;
  logic              err_r;
  logic [DW-1:0]     rdata_r;
  logic              write_r;
  logic [AW-1:0]     addr_r;
  logic [DW-1:0]     wdata_r;
  logic [SW-1:0]     strb_r;

  logic              win_found;
  logic [GW-1:0]     win_id;
  logic [GW-1:0]     ptr_nxt;
  logic              xfer_done;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     tmo_cnt;
`endif

  // Round-robin search: first set REQ bit at or above ptr, wrapping.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_r) + k) % NREQ;
      if (!win_found && bus.REQ[idx]) begin
        win_found = 1'b1;
        win_id    = idx[GW-1:0];
      end
    end
  end

  assign ptr_nxt   = (win_id == GW'(NREQ - 1)) ? '0 : win_id + 1'b1;

  // A setup phase with PREADY high is not a completion; PENABLE is required.
  assign xfer_done = bus.PSEL & bus.PENABLE & bus.PREADY;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state   <= S_IDLE;
      ptr_r   <= '0;
      gnt_r   <= '0;
      ptx_r   <= 1'b0;
      busy_r  <= 1'b0;
      ack_r   <= '0;
      err_r   <= 1'b0;
      rdata_r <= '0;
      write_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      strb_r  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      // ACK is a single-cycle pulse; it is only set on the BUSY->RESP edge.
      ack_r <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            write_r <= bus.REQ_WRITE[win_id];
            addr_r  <= bus.REQ_ADDR[int'(win_id)*AW +: AW];
            wdata_r <= bus.REQ_WDATA[int'(win_id)*DW +: DW];
            strb_r  <= bus.REQ_STRB[int'(win_id)*SW +: SW];
            gnt_r   <= win_id;
            ptr_r   <= ptr_nxt;
            ptx_r   <= 1'b1;
            busy_r  <= 1'b1;
            state   <= S_BUSY;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        S_BUSY: begin
          if (xfer_done) begin
            // Writes return zero so stale bus data never leaks to a writer.
            rdata_r       <= write_r ? '0 : bus.PRDATA;
            err_r         <= bus.PSLVERR;
            ptx_r         <= 1'b0;
            busy_r        <= 1'b0;
            ack_r[gnt_r]  <= 1'b1;
            state         <= S_RESP;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // This cycle is the TIMEOUT-th BUSY cycle without completion.
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            rdata_r       <= '0;
            err_r         <= 1'b1;
            ptx_r         <= 1'b0;
            busy_r        <= 1'b0;
            ack_r[gnt_r]  <= 1'b1;
            state         <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        // REQ is deliberately ignored here so a requester that drops REQ on
        // the ACK edge is never granted a second time.
        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ACK    = ack_r;
  assign bus.RDATA  = rdata_r;
  assign bus.ERR    = err_r;
  assign bus.GNT_ID = gnt_r;
  assign bus.BUSY   = busy_r;
  assign bus.PTX    = ptx_r;
  assign bus.WRITE  = write_r;
  assign bus.ADDR   = addr_r;
  assign bus.WDATA  = wdata_r;
  assign bus.STRB   = strb_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Bench for apb_req_arbiter (NREQ=4, AW=8, DW=32, TIMEOUT=16). Drives the
// requesters and a simple APB bus responder through the interface; checks a
// directed vector table, hand-written multi-cycle sequences (fairness, reset
// mid-transfer, timeout when APB_ARB_TIMEOUT_EN is defined) and randomized
// transactions against a round-robin reference model.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

  logic PCLK = 1'b0;
  logic PRESET = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_req_arbiter_if #(.NREQ(4), .AW(8), .DW(32)) bus ();

  apb_req_arbiter #(.NREQ(4), .AW(8), .DW(32), .TIMEOUT(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  mask;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] prd;
    logic        slverr;
    int          gnt;
    logic [3:0]  exp_ack;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vec [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic w, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    bus.REQ_WRITE[i]        = w;
    bus.REQ_ADDR[i*8 +: 8]  = a;
    bus.REQ_WDATA[i*32 +: 32] = d;
    bus.REQ_STRB[i*4 +: 4]  = s;
  endtask

  // Returns the number of negedges until BUSY is seen (0 on expiry).
  task automatic wait_busy(input int max, output int cycles);
    cycles = 0;
    for (int c = 1; c <= max; c++) begin
      @(negedge PCLK);
      if (bus.BUSY) begin
        cycles = c;
        break;
      end
    end
    if (cycles == 0) check("busy_wait_expired", 64'(0), 64'(1));
  endtask

  // Called at the negedge where BUSY is first visible; returns at the
  // negedge where ACK should be visible.
  task automatic bus_xfer(input int waits, input logic [31:0] prd, input logic slverr,
                          output logic [3:0] ack, output logic [31:0] rd, output logic er);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PREADY = 1'b1;
    bus.PRDATA = prd; bus.PSLVERR = slverr;
    @(negedge PCLK);
    check("setup_not_done", 64'({bus.BUSY, bus.PTX, bus.ACK}), 64'({1'b1, 1'b1, 4'b0}));
    bus.PENABLE = 1'b1;
    bus.PREADY  = (waits == 0);
    for (int w = 0; w < waits; w++) begin
      @(negedge PCLK);
      check("wait_state_busy", 64'({bus.BUSY, bus.PTX, bus.ACK}), 64'({1'b1, 1'b1, 4'b0}));
      if (w == waits - 1) bus.PREADY = 1'b1;
    end
    @(negedge PCLK);
    ack = bus.ACK; rd = bus.RDATA; er = bus.ERR;
    check("resp_ptx_busy_low", 64'({bus.PTX, bus.BUSY}), 64'(0));
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
  endtask

  // Reference model: round-robin winner from plain modular search.
  function automatic int rr_pick(input logic [3:0] mask, input int p);
    for (int k = 0; k < 4; k++)
      if (mask[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int          cyc;
    logic [3:0]  ack;
    logic [31:0] rd;
    logic        er;
    int          m_ptr;
    int          win;
    int          exp_lat;
    logic [3:0]  mask;
    logic        rw [4];
    logic [7:0]  ra [4];
    logic [31:0] rdw [4];
    logic [3:0]  rs [4];
    logic [31:0] prd;
    logic        serr;
    int          waits;

    vec[0] = '{4'b0100, 1'b1, 8'h3C, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 1'b0, 2, 4'b0100, 32'h0,        1'b0};
    vec[1] = '{4'b0001, 1'b0, 8'h10, 32'h00000000, 4'h0, 3, 32'h12345678, 1'b0, 0, 4'b0001, 32'h12345678, 1'b0};
    vec[2] = '{4'b1000, 1'b1, 8'hA5, 32'h0F0F0F0F, 4'h3, 1, 32'hFFFFFFFF, 1'b1, 3, 4'b1000, 32'h0,        1'b1};
    vec[3] = '{4'b1010, 1'b0, 8'h44, 32'h11111111, 4'h1, 0, 32'h0BADF00D, 1'b1, 1, 4'b0010, 32'h0BADF00D, 1'b1};
    vec[4] = '{4'b0011, 1'b0, 8'h7E, 32'h22222222, 4'h8, 1, 32'h00000001, 1'b0, 0, 4'b0001, 32'h00000001, 1'b0};
    vec[5] = '{4'b1001, 1'b1, 8'hC3, 32'h76543210, 4'hC, 2, 32'h55555555, 1'b0, 3, 4'b1000, 32'h0,        1'b0};

    bus.REQ = '0; bus.REQ_WRITE = '0; bus.REQ_ADDR = '0; bus.REQ_WDATA = '0; bus.REQ_STRB = '0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;

    // Reset state
    repeat (2) @(negedge PCLK);
    check("reset_ctrl", 64'({bus.PTX, bus.BUSY, bus.ACK, bus.ERR, bus.GNT_ID, bus.WRITE}), 64'(0));
    check("reset_data", {bus.RDATA, bus.WDATA}, 64'(0));
    check("reset_addr_strb", 64'({bus.ADDR, bus.STRB}), 64'(0));
    PRESET = 1'b1;
    @(negedge PCLK);

    // Directed vector table
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == vec[t].gnt)
          set_fields(i, vec[t].wr, vec[t].addr, vec[t].wdata, vec[t].strb);
        else
          set_fields(i, ~vec[t].wr, ~vec[t].addr, ~vec[t].wdata, ~vec[t].strb);
      end
      bus.REQ = vec[t].mask;
      wait_busy(8, cyc);
      check("tv_latency", 64'(cyc), 64'(1));
      check("tv_gnt", 64'(bus.GNT_ID), 64'(vec[t].gnt));
      check("tv_fields", 64'({bus.PTX, bus.WRITE, bus.ADDR, bus.WDATA, bus.STRB}),
            64'({1'b1, vec[t].wr, vec[t].addr, vec[t].wdata, vec[t].strb}));
      bus_xfer(vec[t].waits, vec[t].prd, vec[t].slverr, ack, rd, er);
      check("tv_ack", 64'(ack), 64'(vec[t].exp_ack));
      check("tv_rdata", 64'(rd), 64'(vec[t].exp_rd));
      check("tv_err", 64'(er), 64'(vec[t].exp_err));
      bus.REQ = '0;
      @(negedge PCLK);
      check("tv_ack_one_cycle", 64'(bus.ACK), 64'(0));
    end

    // Fairness: all requesters held high, pointer is back at 0
    for (int i = 0; i < 4; i++) set_fields(i, 1'b1, 8'(i * 16), 32'(i), 4'hF);
    bus.REQ = 4'hF;
    for (int j = 0; j < 8; j++) begin
      wait_busy(8, cyc);
      check("fair_latency", 64'(cyc), 64'((j == 0) ? 1 : 2));
      check("fair_gnt", 64'(bus.GNT_ID), 64'(j % 4));
      bus_xfer(0, 32'h0, 1'b0, ack, rd, er);
      check("fair_ack", 64'(ack), 64'(4'b0001 << (j % 4)));
    end
    bus.REQ = '0;
    @(negedge PCLK);

    // Reset mid-transfer: first leave nonzero RDATA/ERR and ptr=2
    set_fields(1, 1'b0, 8'h21, 32'h0, 4'h0);
    bus.REQ = 4'b0010;
    wait_busy(8, cyc);
    check("pre_rst_gnt", 64'(bus.GNT_ID), 64'(1));
    bus_xfer(0, 32'hCAFE0001, 1'b1, ack, rd, er);
    check("pre_rst_resp", 64'({ack, rd, er}), 64'({4'b0010, 32'hCAFE0001, 1'b1}));
    bus.REQ = '0;
    @(negedge PCLK);
    set_fields(2, 1'b1, 8'h55, 32'h12121212, 4'h3);
    bus.REQ = 4'b0100;
    wait_busy(8, cyc);
    check("mid_rst_gnt", 64'(bus.GNT_ID), 64'(2));
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PREADY = 1'b0;
    #2 PRESET = 1'b0;
    #1;
    check("rst_async_ctrl", 64'({bus.PTX, bus.BUSY, bus.ACK, bus.ERR, bus.GNT_ID, bus.WRITE}), 64'(0));
    check("rst_async_data", {bus.RDATA, bus.WDATA}, 64'(0));
    check("rst_async_addr_strb", 64'({bus.ADDR, bus.STRB}), 64'(0));
    bus.PSEL = 1'b0;
    @(negedge PCLK);
    check("rst_no_ack", 64'({bus.ACK, bus.BUSY}), 64'(0));
    for (int i = 0; i < 4; i++) set_fields(i, 1'b0, 8'(i + 1), 32'(i + 1), 4'(i + 1));
    bus.REQ = 4'hF;
    PRESET = 1'b1;
    wait_busy(8, cyc);
    check("post_rst_gnt", 64'(bus.GNT_ID), 64'(0));
    bus_xfer(0, 32'h00C0FFEE, 1'b0, ack, rd, er);
    check("post_rst_ack", 64'({ack, rd}), 64'({4'b0001, 32'h00C0FFEE}));
    bus.REQ = '0;
    @(negedge PCLK);

    // Randomized transactions against the round-robin model
    m_ptr   = 1;
    exp_lat = 1;
    mask    = 4'($urandom_range(1, 15));
    for (int i = 0; i < 4; i++) begin
      rw[i] = 1'($urandom); ra[i] = 8'($urandom); rdw[i] = $urandom; rs[i] = 4'($urandom);
      set_fields(i, rw[i], ra[i], rdw[i], rs[i]);
    end
    bus.REQ = mask;
    for (int n = 0; n < 40; n++) begin
      win   = rr_pick(mask, m_ptr);
      m_ptr = (win + 1) % 4;
      wait_busy(8, cyc);
      check("rnd_latency", 64'(cyc), 64'(exp_lat));
      check("rnd_gnt", 64'(bus.GNT_ID), 64'(win));
      check("rnd_fields", 64'({bus.WRITE, bus.ADDR, bus.WDATA, bus.STRB}),
            64'({rw[win], ra[win], rdw[win], rs[win]}));
      // Disturb the other requesters while BUSY; the winner's REQ stays high.
      bus.REQ = 4'($urandom) | (4'b0001 << win);
      for (int i = 0; i < 4; i++)
        if (i != win) set_fields(i, 1'($urandom), 8'($urandom), $urandom, 4'($urandom));
      waits = $urandom_range(0, 3);
      prd   = $urandom;
      serr  = 1'($urandom);
      bus_xfer(waits, prd, serr, ack, rd, er);
      check("rnd_ack", 64'(ack), 64'(4'b0001 << win));
      check("rnd_rdata", 64'(rd), 64'(rw[win] ? 32'h0 : prd));
      check("rnd_err", 64'(er), 64'(serr));
      check("rnd_hold", 64'({bus.WRITE, bus.ADDR, bus.WDATA, bus.STRB}),
            64'({rw[win], ra[win], rdw[win], rs[win]}));
      // New requests appear during RESP and must wait for IDLE.
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        rw[i] = 1'($urandom); ra[i] = 8'($urandom); rdw[i] = $urandom; rs[i] = 4'($urandom);
        set_fields(i, rw[i], ra[i], rdw[i], rs[i]);
      end
      bus.REQ = mask;
      exp_lat = 2;
    end
    bus.REQ = '0;
    repeat (3) @(negedge PCLK);

`ifdef APB_ARB_TIMEOUT_EN
    // Timeout: PREADY never rises
    set_fields(0, 1'b0, 8'h99, 32'h0, 4'h0);
    bus.REQ = 4'b0001;
    wait_busy(8, cyc);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PREADY = 1'b0; bus.PRDATA = 32'hFEEDFACE;
    cyc = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge PCLK);
      if (!bus.PTX) break;
      cyc++;
    end
    check("tmo_busy_cycles", 64'(cyc), 64'(16));
    check("tmo_resp", 64'({bus.ACK, bus.ERR, bus.RDATA}), 64'({4'b0001, 1'b1, 32'h0}));
    bus.REQ = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(negedge PCLK);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
